// File: rtl/hack_prog_loader.sv
// hack_prog_loader
//   Byte-stream program loader for the HACK computer. Receives framed program
//   images (SYNC, LEN_HI, LEN_LO, N x {hi, lo}, CHK), writes each assembled
//   16-bit word into instruction memory, and holds the CPU in reset until a
//   frame passes its XOR checksum.
// Ports
//   clock, reset_n        system clock, async active-low reset
//   rx_data/rx_valid      host byte stream; consumed on rx_valid & rx_ready
//   rx_ready              loader can take a byte this cycle
//   ins_memfull           instruction memory full; aborts the frame on a write
//   write_ins/addr_ins/dati_ins  one-cycle instruction-memory write port
//   cpu_reset_n           active-low CPU reset, released after a good frame
//   busy/done/err/err_code  frame progress and sticky result of the last frame
//                         (01 too long, 10 checksum, 11 memory full)
module hack_prog_loader #(
  parameter int unsigned ADDR_WIDTH = 15,
  parameter int unsigned MAX_WORDS  = 32768,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic        ins_memfull,
  output logic        write_ins,
  output logic [15:0] addr_ins,
  output logic [15:0] dati_ins,
  output logic        cpu_reset_n,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code
);

  // One extra index bit so that index+1 == MAX_WORDS is representable.
  localparam int unsigned IW = ADDR_WIDTH + 1;

  typedef enum logic [3:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DAT_HI, S_DAT_LO, S_WRITE, S_CHK, S_DONE, S_ERR
  } state_e;

  // Reset synchronizer: assertion is immediate, release waits two edges.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  state_e          state_q, state_d;
  logic [15:0]     len_q, len_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [7:0]      hi_q, hi_d, lo_q, lo_d;
  logic [7:0]      chk_q, chk_d;
  logic            busy_q, busy_d, done_q, done_d, err_q, err_d, cpu_q, cpu_d;
  logic [1:0]      code_q, code_d;

  logic            acc;
  logic [15:0]     n_w;
  logic [IW-1:0]   idx_nxt;

  assign acc     = rx_valid & rx_ready;
  assign n_w     = {len_q[15:8], rx_data};
  assign idx_nxt = idx_q + 1'b1;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      chk_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cpu_q   <= 1'b0;
      code_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      chk_q   <= chk_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cpu_q   <= cpu_d;
      code_q  <= code_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    chk_d     = chk_q;
    busy_d    = busy_q;
    done_d    = done_q;
    err_d     = err_q;
    cpu_d     = cpu_q;
    code_d    = code_q;
    rx_ready  = 1'b1;
    write_ins = 1'b0;

    // Every byte between SYNC and CHK feeds the checksum.
    if (acc && (state_q inside {S_LEN_HI, S_LEN_LO, S_DAT_HI, S_DAT_LO}))
      chk_d = chk_q ^ rx_data;

    case (state_q)
      S_IDLE: begin
        if (acc && rx_data == SYNC_BYTE) begin
          state_d = S_LEN_HI;
          done_d  = 1'b0;
          err_d   = 1'b0;
          code_d  = 2'b00;
          cpu_d   = 1'b0;
          busy_d  = 1'b1;
          idx_d   = '0;
          chk_d   = '0;
        end
      end
      S_LEN_HI: begin
        if (acc) begin
          len_d   = {rx_data, 8'h00};
          state_d = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (acc) begin
          len_d = n_w;
          if (32'(n_w) > MAX_WORDS) begin
            state_d = S_ERR;
            code_d  = 2'b01;
          end else if (n_w == 16'd0) begin
            state_d = S_CHK;
          end else begin
            state_d = S_DAT_HI;
          end
        end
      end
      S_DAT_HI: begin
        if (acc) begin
          hi_d    = rx_data;
          state_d = S_DAT_LO;
        end
      end
      S_DAT_LO: begin
        if (acc) begin
          lo_d    = rx_data;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        rx_ready = 1'b0;
        if (ins_memfull) begin
          state_d = S_ERR;
          code_d  = 2'b11;
        end else begin
          write_ins = 1'b1;
          idx_d     = idx_nxt;
          state_d   = (32'(idx_nxt) == 32'(len_q)) ? S_CHK : S_DAT_HI;
        end
      end
      S_CHK: begin
        if (acc) begin
          if (rx_data == chk_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ERR;
            code_d  = 2'b10;
          end
        end
      end
      S_DONE: begin
        rx_ready = 1'b0;
        done_d   = 1'b1;
        cpu_d    = 1'b1;
        busy_d   = 1'b0;
        state_d  = S_IDLE;
      end
      S_ERR: begin
        rx_ready = 1'b0;
        err_d    = 1'b1;
        busy_d   = 1'b0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Index < N <= MAX_WORDS during WRITE, so the top index bit is never
  // needed on the address bus.
  assign addr_ins    = 16'(idx_q[ADDR_WIDTH-1:0]);
  assign dati_ins    = {hi_q, lo_q};
  assign cpu_reset_n = cpu_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign err_code    = code_q;

endmodule
